// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default operand width
// and the controller state encoding.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with the borrow produced
// toward the next more significant bit.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - b_in one bit per clock, LSB first,
// and publishes the result in a separate output register on entry to DONE.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic [WIDTH-1:0] diff_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             borrow_sr;
  logic             a_msb;
  logic             b_msb;
  logic             borrow_reg;
  logic             ovf_reg;
  logic             fs_d;
  logic             fs_bout;
  logic             diff_sr_unused;

  full_subtractor u_full_subtractor (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (borrow_sr),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // The LSB of diff_sr is always shifted out; the final bit comes straight from fs_d.
  assign diff_sr_unused = diff_sr[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt_reg == LAST_BIT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      diff_sr    <= '0;
      diff_reg   <= '0;
      cnt_reg    <= '0;
      borrow_sr  <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      borrow_reg <= 1'b0;
      ovf_reg    <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      a_sr      <= a;
      b_sr      <= b;
      borrow_sr <= b_in;
      a_msb     <= a[WIDTH-1];
      b_msb     <= b[WIDTH-1];
      diff_sr   <= '0;
      cnt_reg   <= '0;
    end else if (state_reg == SHIFT) begin
      a_sr      <= a_sr >> 1;
      b_sr      <= b_sr >> 1;
      diff_sr   <= {fs_d, diff_sr[WIDTH-1:1]};
      borrow_sr <= fs_bout;
      cnt_reg   <= cnt_reg + CNT_W'(1);
      // Sign bit is being processed: the visible result is updated only now.
      if (cnt_reg == LAST_BIT) begin
        diff_reg   <= {fs_d, diff_sr[WIDTH-1:1]};
        borrow_reg <= fs_bout;
        ovf_reg    <= (a_msb ^ b_msb) & (fs_d ^ a_msb);
      end
    end
  end

  assign diff       = diff_reg;
  assign borrow_out = borrow_reg;
  assign ovf        = ovf_reg;

endmodule
